// File: rtl/bird_pkg.sv
// Shared types and constants for the bird slot lifecycle logic.
package bird_pkg;

  typedef enum logic [2:0] {
    B_IDLE,
    B_SPAWN,
    B_ACTIVE,
    B_FLASH,
    B_DYING
  } bird_state_t;

  localparam int DMG_NORMAL = 1;
  localparam int DMG_BOOST  = 2;

  // Width of a down-counter able to hold the largest (frames - 1) load value.
  function automatic int frame_cnt_w(input int spawn_f, input int flash_f, input int death_f);
    int m;
    m = spawn_f;
    if (flash_f > m) m = flash_f;
    if (death_f > m) m = death_f;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bird_slot_fsm.sv
// One bird slot: deploy edge detect, health, frame counter, lifecycle state and output decode.
module bird_slot_fsm
  import bird_pkg::*;
#(
  parameter int LIFE_W       = 4,
  parameter int SPAWN_FRAMES = 32,
  parameter int FLASH_FRAMES = 8,
  parameter int DEATH_FRAMES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic              deploy,
  input  logic [LIFE_W-1:0] bird_life,
  input  logic              more_damage,
  input  logic              hit,
  output logic              alive,
  output logic              visible,
  output logic              flash,
  output logic              dying,
  output logic              kill_pulse
);

  localparam int CNT_W = frame_cnt_w(SPAWN_FRAMES, FLASH_FRAMES, DEATH_FRAMES);
  localparam logic [CNT_W-1:0] SPAWN_LOAD = CNT_W'(SPAWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_FRAMES - 1);

  bird_state_t       state, state_nx;
  logic [LIFE_W-1:0] hp, hp_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              deploy_q;
  logic              kill_q, kill_nx;
  logic              deploy_edge;
  logic [LIFE_W-1:0] dmg;

  assign deploy_edge = deploy & ~deploy_q;
  assign dmg         = more_damage ? LIFE_W'(DMG_BOOST) : LIFE_W'(DMG_NORMAL);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    hp_nx    = hp;
    cnt_nx   = cnt;
    kill_nx  = 1'b0;
    case (state)
      B_IDLE: begin
        if (deploy_edge) begin
          state_nx = B_SPAWN;
          hp_nx    = (bird_life == '0) ? LIFE_W'(1) : bird_life;
          cnt_nx   = SPAWN_LOAD;
        end
      end
      B_SPAWN, B_FLASH: begin
        if (startOfFrame) begin
          if (cnt == '0) state_nx = B_ACTIVE;
          else           cnt_nx   = cnt - CNT_W'(1);
        end
      end
      B_ACTIVE: begin
        // hp <= dmg goes straight to DYING, so the subtraction below can never wrap.
        if (hit) begin
          if (hp <= dmg) begin
            state_nx = B_DYING;
            hp_nx    = '0;
            cnt_nx   = DEATH_LOAD;
            kill_nx  = 1'b1;
          end else begin
            state_nx = B_FLASH;
            hp_nx    = hp - dmg;
            cnt_nx   = FLASH_LOAD;
          end
        end
      end
      B_DYING: begin
        if (startOfFrame) begin
          if (cnt == '0) state_nx = B_IDLE;
          else           cnt_nx   = cnt - CNT_W'(1);
        end
      end
      default: state_nx = B_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= B_IDLE;
      hp       <= '0;
      cnt      <= '0;
      deploy_q <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      hp       <= hp_nx;
      cnt      <= cnt_nx;
      deploy_q <= deploy;
      kill_q   <= kill_nx;
    end
  end

  assign alive      = (state == B_SPAWN) || (state == B_ACTIVE) || (state == B_FLASH);
  assign visible    = (state != B_IDLE);
  assign flash      = (state == B_FLASH) || ((state == B_SPAWN) && cnt[2]);
  assign dying      = (state == B_DYING);
  assign kill_pulse = kill_q;

endmodule

// File: rtl/bird_life_manager.sv
// Per-slot bird health and lifecycle tracking; one bird_slot_fsm per slot.
module bird_life_manager
  import bird_pkg::*;
#(
  parameter int NUM_BIRDS    = 4,
  parameter int LIFE_W       = 4,
  parameter int SPAWN_FRAMES = 32,
  parameter int FLASH_FRAMES = 8,
  parameter int DEATH_FRAMES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [NUM_BIRDS-1:0] deploy_bird,
  input  logic [LIFE_W-1:0]    bird_life,
  input  logic                 more_damage,
  input  logic [NUM_BIRDS-1:0] bird_hit,
  output logic [NUM_BIRDS-1:0] bird_alive,
  output logic [NUM_BIRDS-1:0] bird_visible,
  output logic [NUM_BIRDS-1:0] bird_flash,
  output logic [NUM_BIRDS-1:0] bird_dying,
  output logic [NUM_BIRDS-1:0] kill_pulse
);

  for (genvar i = 0; i < NUM_BIRDS; i++) begin : g_slot
    bird_slot_fsm #(
      .LIFE_W      (LIFE_W),
      .SPAWN_FRAMES(SPAWN_FRAMES),
      .FLASH_FRAMES(FLASH_FRAMES),
      .DEATH_FRAMES(DEATH_FRAMES)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .startOfFrame(startOfFrame),
      .deploy      (deploy_bird[i]),
      .bird_life   (bird_life),
      .more_damage (more_damage),
      .hit         (bird_hit[i]),
      .alive       (bird_alive[i]),
      .visible     (bird_visible[i]),
      .flash       (bird_flash[i]),
      .dying       (bird_dying[i]),
      .kill_pulse  (kill_pulse[i])
    );
  end

endmodule
